// File: rtl/rv_pkg.sv
// Shared integer-register-file constants and types for the regfile_rd slice.
package rv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : rv_pkg

// File: rtl/regfile_bypass_mux.sv
// Read-value selection for one register-file read port:
// x0 reads as zero, an in-flight write-back may be forwarded, else the array.
module regfile_bypass_mux
  import rv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int BYPASS = 1
) (
  input  reg_idx_t         addr,
  input  logic             op_write,
  input  reg_idx_t         write_addr,
  input  logic [XLEN-1:0]  write_data,
  input  logic [XLEN-1:0]  mem_q,
  output logic [XLEN-1:0]  value
);

  logic w_hit;

  assign w_hit = (BYPASS != 0) && op_write && (write_addr == addr);

  // Resolve x0 first, then forwarding, then the stored value.
  always_comb begin
    value = mem_q;
    if (addr == REG_ZERO) begin
      value = '0;
    end else if (w_hit) begin
      value = write_data;
    end else begin
      value = mem_q;
    end
  end

endmodule : regfile_bypass_mux

// File: rtl/regfile_rd.sv
// 32 x XLEN integer register file with two registered read ports,
// write-to-read bypass, stall hold and a written-since-reset scoreboard.
// Optional debug read port enabled by defining REGFILE_DBG_PORT_EN.
module regfile_rd
  import rv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_write,
  input  reg_idx_t         write_addr,
  input  logic [XLEN-1:0]  write_data,
  input  logic             rd_req,
  input  logic             stall,
  input  reg_idx_t         rs1_addr,
  input  reg_idx_t         rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rd_valid,
`ifdef REGFILE_DBG_PORT_EN
  input  reg_idx_t         dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
`endif
  output logic [NREGS-1:0] written
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_written;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic             r_rd_valid;

  logic [XLEN-1:0]  w_rs1_value;
  logic [XLEN-1:0]  w_rs2_value;
  logic             w_wr_en;
  logic             w_rd_accept;

  // x0 is never stored, so its array slot stays at its reset value of zero.
  assign w_wr_en     = op_write && (write_addr != REG_ZERO);
  assign w_rd_accept = rd_req && !stall;

  regfile_bypass_mux #(.XLEN(XLEN), .BYPASS(BYPASS)) u_mux_rs1 (
    .addr       (rs1_addr),
    .op_write   (op_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .mem_q      (r_mem[rs1_addr]),
    .value      (w_rs1_value)
  );

  regfile_bypass_mux #(.XLEN(XLEN), .BYPASS(BYPASS)) u_mux_rs2 (
    .addr       (rs2_addr),
    .op_write   (op_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .mem_q      (r_mem[rs2_addr]),
    .value      (w_rs2_value)
  );

  // Register array and written-since-reset flags; reset wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
      r_written <= '0;
    end else if (w_wr_en) begin
      r_mem[write_addr]     <= write_data;
      r_written[write_addr] <= 1'b1;
    end else begin
      r_written <= r_written;
    end
  end

  // Read port registers: capture on accept, drop valid when idle, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd_valid <= 1'b0;
    end else if (stall) begin
      r_rd_valid <= r_rd_valid;
    end else if (w_rd_accept) begin
      r_rs1_data <= w_rs1_value;
      r_rs2_data <= w_rs2_value;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;
  assign rd_valid = r_rd_valid;
  assign written  = r_written;

`ifdef REGFILE_DBG_PORT_EN
  // Unbypassed peek at the array for debug; never touches the read pipeline.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr == REG_ZERO) begin
      dbg_data = '0;
    end else begin
      dbg_data = r_mem[dbg_addr];
    end
  end
`endif

endmodule : regfile_rd

// File: tb/tb_regfile_rd.sv
// Scoreboard bench for regfile_rd: the driver pushes expected read data,
// a negedge monitor pops and compares whenever rd_valid is high.
module tb_regfile_rd;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int BYPASS = 1;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_write;
  logic [4:0]       write_addr;
  logic [XLEN-1:0]  write_data;
  logic             rd_req;
  logic             stall;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             rd_valid;
  logic [NREGS-1:0] written;
`ifdef REGFILE_DBG_PORT_EN
  logic [4:0]       dbg_addr = 5'd0;
  logic [XLEN-1:0]  dbg_data;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_rd #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_write   (op_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .rd_req     (rd_req),
    .stall      (stall),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_valid   (rd_valid),
`ifdef REGFILE_DBG_PORT_EN
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
`endif
    .written    (written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, return at the following negedge.
  task automatic step(input logic w, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                      input logic rq, input logic st, input logic [4:0] a1, input logic [4:0] a2);
    op_write   = w;
    write_addr = wa;
    write_data = wd;
    rd_req     = rq;
    stall      = st;
    rs1_addr   = a1;
    rs2_addr   = a2;
    @(negedge clk);
  endtask

  task automatic push(input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    exp_t e;
    e.rs1 = e1;
    e.rs2 = e2;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents valid data, compare against the queue head.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got rd_valid=1 rs1=0x%0h expected no pending read", rs1_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rs1_data", rs1_data, e.rs1);
        check("rs2_data", rs2_data, e.rs2);
      end
    end
  end

  initial begin
    logic [XLEN-1:0] v_old;
    logic [XLEN-1:0] v_new;
    logic [XLEN-1:0] v_byp;
    v_old = 64'h0000_0000_0000_000A;
    v_new = 64'h0000_0000_0000_000B;
    v_byp = (BYPASS != 0) ? v_new : v_old;

    reset = 1'b1;
    op_write = 1'b0; write_addr = 5'd0; write_data = '0;
    rd_req = 1'b0; stall = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("reset_rs1", rs1_data, 64'd0);
    check("reset_written", {32'd0, written}, 64'd0);

    // Reset clears the array and overrides a simultaneous write/read.
    step(1'b1, 5'd5, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 5'd0, 5'd0);
    reset = 1'b1;
    step(1'b1, 5'd6, 64'h6666_6666_6666_6666, 1'b1, 1'b0, 5'd6, 5'd6);
    reset = 1'b0;
    check("rst_override_written", {32'd0, written}, 64'd0);
    check("rst_override_valid", {63'd0, rd_valid}, 64'd0);
    push(64'd0, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd5, 5'd6);

    // Basic write then read.
    step(1'b1, 5'd3, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 5'd0, 5'd0);
    push(64'hDEAD_BEEF_0000_0001, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd3, 5'd0);
    check("written_x3", {32'd0, written}, 64'h8);

    // x0 immunity.
    step(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd0);
    push(64'd0, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd0, 5'd0);
    check("written_x0", {32'd0, written}, 64'h8);

    // Same-cycle bypass on both ports, then the committed value.
    step(1'b1, 5'd7, v_old, 1'b0, 1'b0, 5'd0, 5'd0);
    push(v_byp, v_byp);
    step(1'b1, 5'd7, v_new, 1'b1, 1'b0, 5'd7, 5'd7);
    push(v_new, v_new);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd7, 5'd7);
    check("written_x7", {32'd0, written}, 64'h88);

    // Stall hold while writing underneath, then release sees the new value.
    step(1'b1, 5'd3, 64'h5, 1'b0, 1'b0, 5'd0, 5'd0);
    push(64'h5, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd3, 5'd0);
    for (int i = 0; i < 3; i++) begin
      push(64'h5, 64'd0);
      step(1'b1, 5'd3, 64'h9, 1'b1, 1'b1, 5'd3, 5'd7);
    end
    push(64'h9, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd3, 5'd0);

    // Idle drop: valid falls, data holds.
    push(v_new, 64'h9);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd7, 5'd3);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd3, 5'd7);
    check("idle_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("idle_rs1_hold", rs1_data, v_new);
    check("idle_rs2_hold", rs2_data, 64'h9);

    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    check("pending_reads", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_rd

// File: doc/regfile_rd.md
Name: regfile_rd

Overview:
- Integer register file that receives the write-back stage's registered write (op_write, write_data, write_addr) and serves two registered read ports to decode/execute.
- 32 x 64-bit registers; x0 hardwired to zero.
- Same-cycle write-to-read bypass, so decode sees a value being retired in the same cycle.
- Pipeline stall hold and a per-register written-since-reset scoreboard for hazard debug.

Parameters:
- XLEN, 64, data width of each register and of every data port.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = read returns the pre-write value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op_write  in  1  write enable from write-back.
- write_addr  in  5  destination register index.
- write_data  in  XLEN  value to write.
- rd_req  in  1  read request; both ports are sampled together.
- stall  in  1  hold both read outputs and rd_valid.
- rs1_addr  in  5  read port 1 index.
- rs2_addr  in  5  read port 2 index.
- rs1_data  out  XLEN  registered read data, port 1.
- rs2_data  out  XLEN  registered read data, port 2.
- rd_valid  out  1  read data valid, one cycle after an accepted rd_req.
- written  out  NREGS  bit i set once register i has been written since reset; bit 0 always 0.

Behaviour:
- Reset:
  - Evaluated at the clock edge with reset=1.
  - All registers cleared to 0; rs1_data, rs2_data and rd_valid = 0; written = 0.
  - Reset overrides any simultaneous write, read or stall.
- Write:
  - At a posedge with op_write=1 and write_addr!=0: mem[write_addr] <= write_data and written[write_addr] <= 1.
  - Writes to x0 are dropped and do not set written[0].
- Read acceptance:
  - A request is accepted at a posedge with rd_req=1 and stall=0.
  - rsN_data <= value(rsN_addr); rd_valid <= 1.
- Read latency: exactly 1 cycle from the accepting edge.
- No request: at a posedge with rd_req=0 and stall=0, rd_valid <= 0 and the data outputs keep their last value.
- Stall: at a posedge with stall=1, rs1_data, rs2_data and rd_valid hold. Writes still occur.
- value(a) is resolved in this order:
  1. a==0 -> 0.
  2. BYPASS=1 and op_write and write_addr==a -> write_data.
  3. Otherwise mem[a].
- Port independence: both ports may address the same register and both bypass independently.
- BYPASS=0: a same-cycle read of the register being written returns the old value. The new value is visible to a read accepted on the next edge.
- Stall release: on release, the next accepted read uses the current array contents. Writes made during the stall are visible; there is no stale replay.
- The block has no internal FSM beyond the rd_valid flag. All state updates on clk only.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- Defined:
  - Adds dbg_addr (in, 5) and dbg_data (out, XLEN).
  - dbg_data is a combinational, unbypassed read of mem[dbg_addr]; it returns 0 for x0.
  - The port has no effect on the functional ports.
- Undefined: ports and logic are absent; the functional behaviour is identical.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and REG_ADDR_W=5 constants.
  - REG_ZERO=5'd0 constant.
  - typedef xlen_t (logic [XLEN-1:0]) and reg_idx_t (logic [4:0]).
- One sub-module is natural: regfile_bypass_mux.
  - Combinational: (addr, op_write, write_addr, write_data, mem_q) -> value.
  - Instantiated once per read port.

Test Plan:
- Reset clears the array:
  - Write x5=0x1111_2222_3333_4444, then assert reset for 1 cycle.
  - Read x5 -> rs1_data=0 and written=0.
- Basic write/read:
  - op_write=1, write_addr=3, write_data=0xDEAD_BEEF_0000_0001.
  - Next cycle read rs1=3, rs2=0 -> one edge later rs1_data=0xDEAD_BEEF_0000_0001, rs2_data=0, rd_valid=1.
  - written[3]=1.
- x0 immunity: write addr 0 data 0xFFFF_FFFF_FFFF_FFFF, then read x0 on both ports -> both 0; written[0]=0.
- Same-cycle bypass:
  - x7=0xA, then in one cycle write x7=0xB and read rs1=7, rs2=7.
  - BYPASS=1 -> both 0xB.
  - BYPASS=0 -> both 0xA, and the next read returns 0xB.
- Stall hold:
  - Read x3 (value 0x5), then assert stall for 3 cycles while writing x3=0x9.
  - rs1_data stays 0x5 and rd_valid stays 1 through the stall.
  - First read after release -> 0x9.
- Idle drop: read accepted, then rd_req=0 and stall=0 -> rd_valid=0 on the next edge, rs1_data unchanged.
